alu_rs_dispatch: RTL and testbench
==================================

// Module: alu_rs_dispatch
// PURPOSE
//  ALU reservation station: the receiving end of the rename/dispatch pipeline register. Accepts one
//  dispatched ALU op per cycle, holds up to RS_DEPTH entries, captures missing operands from the CDB
//  and issues ready ops to the ALU. Drives rs_full, which feeds the stall input of the RN/DP register.
// PARAMETERS
//  RS_DEPTH  4   number of entries (2..8)
//  ROB_W     3   ROB index / tag width
//  CNT_W     3   occupancy width, must satisfy 2**CNT_W > RS_DEPTH
// PORTS
//  clk           in   1      clock
//  rst           in   1      reset, synchronous, active-high
//  flush         in   1      synchronous squash of all entries and the issue register
//  dp_valid      in   1      dispatch of an ALU op this cycle
//  dp_pc         in   32     instruction PC
//  dp_alu_ctrl   in   4      ALU operation code
//  dp_rob_dest   in   ROB_W  destination ROB index
//  dp_opa_rdy    in   1      operand A value valid
//  dp_opa_val    in   32     operand A value (used when rdy=1)
//  dp_opa_tag    in   ROB_W  operand A producer ROB index (used when rdy=0)
//  dp_opb_rdy/dp_opb_val/dp_opb_tag   in  1/32/ROB_W   operand B, same meaning
//  cdb_valid     in   1      result broadcast valid
//  cdb_tag       in   ROB_W  ROB index of broadcast result
//  cdb_value     in   32     broadcast result
//  ex_ready      in   1      ALU accepts the issue register this cycle
//  rs_full       out  1      all entries valid; upstream must stall
//  rs_count      out  CNT_W  valid entry count
//  iss_valid     out  1      issue register holds an op
//  iss_pc/iss_alu_ctrl/iss_rob_dest  out 32/4/ROB_W   issued op fields
//  iss_opa/iss_opb  out 32   issued operand values
// BEHAVIOUR
//  - Entry state: valid, pc, ctrl, dest, {rdy,tag,val} per operand. All registered.
//  - rst or flush: all entry valid bits, iss_valid and rs_count go to 0 at the next edge. All iss_* data
//    outputs reset to 0 on rst only; flush leaves them unchanged. flush beats dp_valid, cdb and issue.
//  - rs_full = (rs_count == RS_DEPTH), combinational from registered state. An entry freed this cycle
//    does not clear rs_full until the next cycle.
//  - Allocate: dp_valid && !rs_full writes the lowest-index invalid entry at the edge.
//    dp_valid && rs_full: op dropped, no state change. Upstream stall guarantees this never loses an op.
//  - Alloc bypass: operand with rdy=0 and cdb_valid && cdb_tag==tag in the same cycle is stored rdy=1,
//    val=cdb_value.
//  - Wakeup: every valid entry operand with rdy=0 and a matching cdb_tag captures cdb_value, rdy<=1.
//    Both operands may wake on one broadcast.
//  - Issue select uses registered rdy bits. It picks the lowest-index valid entry with both rdy=1.
//    An entry allocated or woken at edge N is eligible at edge N+1 at the earliest.
//  - Issue register loads when (!iss_valid || ex_ready) and a candidate exists. It copies the fields,
//    clears the entry valid bit and sets iss_valid=1.
//    If (!iss_valid || ex_ready) and no candidate exists, iss_valid<=0.
//    If iss_valid && !ex_ready, all iss_* outputs hold.
//  - Minimum latency: dp_valid with both operands ready at edge N -> iss_valid=1 after edge N+1.
//  - Same-cycle allocate and issue: allocation sees only the free slots from before the edge.
//    A slot freed by issue is reusable the next cycle.
//  - rs_count update per edge: +1 on allocate, -1 on issue, both -> unchanged.
// TESTING
//  1 rst held 2 cycles -> iss_valid=0, rs_full=0, rs_count=0, iss_opa=0.
//  2 dp ADD A=5 B=7 dest=2 both rdy, ex_ready=1 -> iss_valid 2 edges later with opa=5 opb=7
//    rob_dest=2, then rs_count=0.
//  3 dp opa rdy=0 tag=3; cdb tag=3 val=0x10 three cycles later -> iss_opa=0x10 one edge after capture;
//    dp with tag=4 plus same-cycle cdb tag=4 val=0x22 -> issues at minimum latency with opa=0x22.
//  4 four dps all waiting on tag=1 -> rs_full=1, rs_count=4, fifth dp dropped;
//    cdb tag=1 -> entries 0,1,2,3 issue on consecutive cycles.
//  5 iss_valid=1 with ex_ready=0 for 3 cycles -> iss_* stable; ex_ready=1 -> next op loads or iss_valid=0.
//  6 three entries plus iss_valid=1, pulse flush together with dp_valid and cdb_valid
//    -> next cycle rs_count=0, iss_valid=0, rs_full=0.

Source files
------------

// File: rtl/alu_rs_dispatch.sv
// ALU reservation station: holds dispatched ALU ops, snoops the CDB for missing operands and
// issues the lowest-index ready entry into a single issue register in front of the ALU.

module alu_rs_entry #(
  parameter int ROB_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_i,
  input  logic             issue_i,
  input  logic [31:0]      pc_i,
  input  logic [3:0]       ctrl_i,
  input  logic [ROB_W-1:0] dest_i,
  input  logic             a_rdy_i,
  input  logic [31:0]      a_val_i,
  input  logic [ROB_W-1:0] a_tag_i,
  input  logic             b_rdy_i,
  input  logic [31:0]      b_val_i,
  input  logic [ROB_W-1:0] b_tag_i,
  input  logic             cdb_valid_i,
  input  logic [ROB_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_value_i,
  output logic             valid_o,
  output logic [31:0]      pc_o,
  output logic [3:0]       ctrl_o,
  output logic [ROB_W-1:0] dest_o,
  output logic             a_rdy_o,
  output logic [31:0]      a_val_o,
  output logic             b_rdy_o,
  output logic [31:0]      b_val_o
);
  logic             valid_q, a_rdy_q, b_rdy_q;
  logic [31:0]      pc_q, a_val_q, b_val_q;
  logic [3:0]       ctrl_q;
  logic [ROB_W-1:0] dest_q, a_tag_q, b_tag_q;
  logic             a_hit_new, b_hit_new, a_hit_q, b_hit_q;

  // *_new: bypass for an operand arriving with dispatch; *_q: wakeup of a held operand
  assign a_hit_new = cdb_valid_i && (cdb_tag_i == a_tag_i);
  assign b_hit_new = cdb_valid_i && (cdb_tag_i == b_tag_i);
  assign a_hit_q   = valid_q && !a_rdy_q && cdb_valid_i && (cdb_tag_i == a_tag_q);
  assign b_hit_q   = valid_q && !b_rdy_q && cdb_valid_i && (cdb_tag_i == b_tag_q);

  always_ff @(posedge clk) begin
    if (rst || flush)  valid_q <= 1'b0;
    else if (alloc_i)  valid_q <= 1'b1;
    else if (issue_i)  valid_q <= 1'b0;
  end

  // Payload only matters while valid_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (alloc_i) begin
      pc_q    <= pc_i;
      ctrl_q  <= ctrl_i;
      dest_q  <= dest_i;
      a_tag_q <= a_tag_i;
      b_tag_q <= b_tag_i;
      a_rdy_q <= a_rdy_i || a_hit_new;
      b_rdy_q <= b_rdy_i || b_hit_new;
      a_val_q <= a_rdy_i ? a_val_i : cdb_value_i;
      b_val_q <= b_rdy_i ? b_val_i : cdb_value_i;
    end else begin
      if (a_hit_q) begin
        a_rdy_q <= 1'b1;
        a_val_q <= cdb_value_i;
      end
      if (b_hit_q) begin
        b_rdy_q <= 1'b1;
        b_val_q <= cdb_value_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign ctrl_o  = ctrl_q;
  assign dest_o  = dest_q;
  assign a_rdy_o = a_rdy_q;
  assign a_val_o = a_val_q;
  assign b_rdy_o = b_rdy_q;
  assign b_val_o = b_val_q;
endmodule

module alu_rs_dispatch #(
  parameter int RS_DEPTH = 4,
  parameter int ROB_W    = 3,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dp_valid,
  input  logic [31:0]      dp_pc,
  input  logic [3:0]       dp_alu_ctrl,
  input  logic [ROB_W-1:0] dp_rob_dest,
  input  logic             dp_opa_rdy,
  input  logic [31:0]      dp_opa_val,
  input  logic [ROB_W-1:0] dp_opa_tag,
  input  logic             dp_opb_rdy,
  input  logic [31:0]      dp_opb_val,
  input  logic [ROB_W-1:0] dp_opb_tag,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             ex_ready,
  output logic             rs_full,
  output logic [CNT_W-1:0] rs_count,
  output logic             iss_valid,
  output logic [31:0]      iss_pc,
  output logic [3:0]       iss_alu_ctrl,
  output logic [ROB_W-1:0] iss_rob_dest,
  output logic [31:0]      iss_opa,
  output logic [31:0]      iss_opb
);
  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [3:0]       ctrl;
    logic [ROB_W-1:0] dest;
    logic [31:0]      opa;
    logic [31:0]      opb;
  } iss_t;

  logic [RS_DEPTH-1:0]            e_valid, e_a_rdy, e_b_rdy;
  logic [RS_DEPTH-1:0][31:0]      e_pc, e_a_val, e_b_val;
  logic [RS_DEPTH-1:0][3:0]       e_ctrl;
  logic [RS_DEPTH-1:0][ROB_W-1:0] e_dest;

  logic [IDX_W-1:0] free_idx, cand_idx;
  logic             cand_found, alloc_go, iss_adv, iss_load;
  logic             iss_valid_q;
  iss_t             iss_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Lowest-index free slot and lowest-index ready entry, both from registered state.
  always_comb begin
    free_idx   = '0;
    cand_idx   = '0;
    cand_found = 1'b0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!e_valid[i]) free_idx = IDX_W'(i);
      if (e_valid[i] && e_a_rdy[i] && e_b_rdy[i]) begin
        cand_idx   = IDX_W'(i);
        cand_found = 1'b1;
      end
    end
  end

  assign rs_full  = (cnt_q == CNT_W'(RS_DEPTH));
  assign alloc_go = dp_valid && !rs_full;
  assign iss_adv  = !iss_valid_q || ex_ready;
  assign iss_load = iss_adv && cand_found;

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_ent
    alu_rs_entry #(.ROB_W(ROB_W)) u_ent (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .alloc_i     (alloc_go && (free_idx == IDX_W'(g))),
      .issue_i     (iss_load && (cand_idx == IDX_W'(g))),
      .pc_i        (dp_pc),
      .ctrl_i      (dp_alu_ctrl),
      .dest_i      (dp_rob_dest),
      .a_rdy_i     (dp_opa_rdy),
      .a_val_i     (dp_opa_val),
      .a_tag_i     (dp_opa_tag),
      .b_rdy_i     (dp_opb_rdy),
      .b_val_i     (dp_opb_val),
      .b_tag_i     (dp_opb_tag),
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_value_i (cdb_value),
      .valid_o     (e_valid[g]),
      .pc_o        (e_pc[g]),
      .ctrl_o      (e_ctrl[g]),
      .dest_o      (e_dest[g]),
      .a_rdy_o     (e_a_rdy[g]),
      .a_val_o     (e_a_val[g]),
      .b_rdy_o     (e_b_rdy[g]),
      .b_val_o     (e_b_val[g])
    );
  end

  // Issue register: flush drops the valid bit but leaves the last payload in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
    end else if (flush) begin
      iss_valid_q <= 1'b0;
    end else if (iss_adv) begin
      iss_valid_q <= cand_found;
      if (cand_found) begin
        iss_q.pc   <= e_pc[cand_idx];
        iss_q.ctrl <= e_ctrl[cand_idx];
        iss_q.dest <= e_dest[cand_idx];
        iss_q.opa  <= e_a_val[cand_idx];
        iss_q.opb  <= e_b_val[cand_idx];
      end
    end
  end

  assign cnt_d = cnt_q + CNT_W'(alloc_go) - CNT_W'(iss_load);

  always_ff @(posedge clk) begin
    if (rst || flush) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  assign rs_count     = cnt_q;
  assign iss_valid    = iss_valid_q;
  assign iss_pc       = iss_q.pc;
  assign iss_alu_ctrl = iss_q.ctrl;
  assign iss_rob_dest = iss_q.dest;
  assign iss_opa      = iss_q.opa;
  assign iss_opb      = iss_q.opb;
endmodule

// File: tb/tb_alu_rs_dispatch.sv
// Bench for alu_rs_dispatch: directed vector table, hand sequences for stall/flush, then random
// traffic checked cycle by cycle against an array-based model of the reservation station.

module tb_alu_rs_dispatch;
  localparam int DEPTH = 4;
  localparam int ROB_W = 3;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst, flush, dp_valid;
  logic [31:0]      dp_pc;
  logic [3:0]       dp_alu_ctrl;
  logic [ROB_W-1:0] dp_rob_dest;
  logic             dp_opa_rdy, dp_opb_rdy;
  logic [31:0]      dp_opa_val, dp_opb_val;
  logic [ROB_W-1:0] dp_opa_tag, dp_opb_tag;
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             ex_ready;
  logic             rs_full;
  logic [CNT_W-1:0] rs_count;
  logic             iss_valid;
  logic [31:0]      iss_pc, iss_opa, iss_opb;
  logic [3:0]       iss_alu_ctrl;
  logic [ROB_W-1:0] iss_rob_dest;

  always #5 clk = ~clk;

  alu_rs_dispatch #(.RS_DEPTH(DEPTH), .ROB_W(ROB_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dp_valid(dp_valid), .dp_pc(dp_pc),
    .dp_alu_ctrl(dp_alu_ctrl), .dp_rob_dest(dp_rob_dest),
    .dp_opa_rdy(dp_opa_rdy), .dp_opa_val(dp_opa_val), .dp_opa_tag(dp_opa_tag),
    .dp_opb_rdy(dp_opb_rdy), .dp_opb_val(dp_opb_val), .dp_opb_tag(dp_opb_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .ex_ready(ex_ready),
    .rs_full(rs_full), .rs_count(rs_count), .iss_valid(iss_valid), .iss_pc(iss_pc),
    .iss_alu_ctrl(iss_alu_ctrl), .iss_rob_dest(iss_rob_dest), .iss_opa(iss_opa), .iss_opb(iss_opb)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit [3:0]  ctrl;
    bit [2:0]  dest;
    bit        ar, br;
    bit [2:0]  at, bt;
    bit [31:0] av, bv;
  } ment_t;

  ment_t m[DEPTH];
  ment_t miss;

  function automatic int mcount();
    int c = 0;
    foreach (m[i]) if (m[i].v) c++;
    return c;
  endfunction

  task automatic model_step();
    ment_t nx[DEPTH];
    int cand, fr, cnt;
    if (rst) begin
      foreach (m[i]) m[i].v = 1'b0;
      miss = '{default: '0};
    end else if (flush) begin
      foreach (m[i]) m[i].v = 1'b0;
      miss.v = 1'b0;
    end else begin
      cnt  = mcount();
      cand = -1;
      fr   = -1;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (m[i].v && m[i].ar && m[i].br) cand = i;
        if (!m[i].v) fr = i;
      end
      nx = m;
      if (cdb_valid)
        foreach (nx[i]) if (nx[i].v) begin
          if (!nx[i].ar && nx[i].at == cdb_tag) begin nx[i].ar = 1'b1; nx[i].av = cdb_value; end
          if (!nx[i].br && nx[i].bt == cdb_tag) begin nx[i].br = 1'b1; nx[i].bv = cdb_value; end
        end
      if (!miss.v || ex_ready) begin
        if (cand >= 0) begin
          miss      = m[cand];
          nx[cand].v = 1'b0;
        end else begin
          miss.v = 1'b0;
        end
      end
      if (dp_valid && cnt < DEPTH) begin
        nx[fr].v    = 1'b1;
        nx[fr].pc   = dp_pc;
        nx[fr].ctrl = dp_alu_ctrl;
        nx[fr].dest = dp_rob_dest;
        nx[fr].at   = dp_opa_tag;
        nx[fr].bt   = dp_opb_tag;
        nx[fr].ar   = dp_opa_rdy || (cdb_valid && cdb_tag == dp_opa_tag);
        nx[fr].br   = dp_opb_rdy || (cdb_valid && cdb_tag == dp_opb_tag);
        nx[fr].av   = dp_opa_rdy ? dp_opa_val : cdb_value;
        nx[fr].bv   = dp_opb_rdy ? dp_opb_val : cdb_value;
      end
      m = nx;
    end
  endtask

  task automatic check_model();
    chk("model_iss_valid", 32'(iss_valid), 32'(miss.v));
    chk("model_rs_count", 32'(rs_count), 32'(mcount()));
    chk("model_rs_full", 32'(rs_full), 32'(mcount() == DEPTH));
    if (miss.v) begin
      chk("model_iss_pc", iss_pc, miss.pc);
      chk("model_iss_ctrl", 32'(iss_alu_ctrl), 32'(miss.ctrl));
      chk("model_iss_dest", 32'(iss_rob_dest), 32'(miss.dest));
      chk("model_iss_opa", iss_opa, miss.av);
      chk("model_iss_opb", iss_opb, miss.bv);
    end
  endtask

  // Inputs are stable from 1ns after an edge until the next edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit        rst, dpv, ar;
    bit [31:0] av;
    bit [2:0]  at;
    bit [31:0] bv;
    bit [2:0]  dest;
    bit        cv;
    bit [2:0]  ct;
    bit [31:0] cval;
    bit        e_iv;
    bit [31:0] e_opa, e_opb;
    bit [2:0]  e_dest, e_cnt;
    bit        e_full;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(int r, int dpv, int ar, int av, int at, int bv, int dest,
                             int cv, int ct, int cval,
                             int iv, int opa, int opb, int edest, int cnt, int full);
    vec_t v;
    v.rst = r[0]; v.dpv = dpv[0]; v.ar = ar[0]; v.av = av; v.at = 3'(at); v.bv = bv;
    v.dest = 3'(dest); v.cv = cv[0]; v.ct = 3'(ct); v.cval = cval;
    v.e_iv = iv[0]; v.e_opa = opa; v.e_opb = opb; v.e_dest = 3'(edest);
    v.e_cnt = 3'(cnt); v.e_full = full[0];
    return v;
  endfunction

  function automatic vec_t I(int iv, int opa, int opb, int edest, int cnt, int full);
    return V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, iv, opa, opb, edest, cnt, full);
  endfunction

  task automatic drv_dp(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] dest);
    dp_valid = v; dp_pc = 32'h2000 + 32'(dest); dp_alu_ctrl = 4'h1; dp_rob_dest = dest;
    dp_opa_rdy = 1'b1; dp_opa_val = a; dp_opa_tag = '0;
    dp_opb_rdy = 1'b1; dp_opb_val = b; dp_opb_tag = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; ex_ready = 1'b1;
    drv_dp(1'b0, 0, 0, 3'd0);

    //      rst dpv ar av   at bv     dest cv ct cval   | iv opa    opb    dest cnt full
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0));
    // both operands ready: issue one edge after allocation
    tbl.push_back(V(0, 1, 1, 5, 0, 7, 2, 0, 0, 0,        0, 0, 0, 0, 1, 0));
    tbl.push_back(I(1, 5, 7, 2, 0, 0));
    tbl.push_back(I(0, 0, 0, 0, 0, 0));
    // operand A waits for tag 3, broadcast three cycles later
    tbl.push_back(V(0, 1, 0, 0, 3, 9, 3, 0, 0, 0,        0, 0, 0, 0, 1, 0));
    tbl.push_back(I(0, 0, 0, 0, 1, 0));
    tbl.push_back(I(0, 0, 0, 0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 3, 'h10,     0, 0, 0, 0, 1, 0));
    tbl.push_back(I(1, 'h10, 9, 3, 0, 0));
    // dispatch bypass: tag 4 broadcast in the dispatch cycle
    tbl.push_back(V(0, 1, 0, 0, 4, 'h33, 4, 1, 4, 'h22, 0, 0, 0, 0, 1, 0));
    tbl.push_back(I(1, 'h22, 'h33, 4, 0, 0));
    tbl.push_back(I(0, 0, 0, 0, 0, 0));
    // fill all four entries waiting on tag 1, fifth dispatch is dropped
    for (int k = 0; k < 4; k++)
      tbl.push_back(V(0, 1, 0, 0, 1, 'h100 + k, k, 0, 0, 0, 0, 0, 0, 0, k + 1, int'(k == 3)));
    tbl.push_back(V(0, 1, 0, 0, 1, 'h200, 5, 0, 0, 0,    0, 0, 0, 0, 4, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h55,     0, 0, 0, 0, 4, 1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(I(1, 'h55, 'h100 + k, k, 3 - k, 0));
    tbl.push_back(I(0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      rst = v.rst; flush = 1'b0; ex_ready = 1'b1;
      dp_valid = v.dpv; dp_pc = 32'h1000 + 4 * i; dp_alu_ctrl = i[3:0]; dp_rob_dest = v.dest;
      dp_opa_rdy = v.ar; dp_opa_val = v.av; dp_opa_tag = v.at;
      dp_opb_rdy = 1'b1; dp_opb_val = v.bv; dp_opb_tag = '0;
      cdb_valid = v.cv; cdb_tag = v.ct; cdb_value = v.cval;
      tick();
      chk($sformatf("tbl%0d_iss_valid", i), 32'(iss_valid), 32'(v.e_iv));
      chk($sformatf("tbl%0d_rs_count", i), 32'(rs_count), 32'(v.e_cnt));
      chk($sformatf("tbl%0d_rs_full", i), 32'(rs_full), 32'(v.e_full));
      if (v.e_iv || v.rst) begin
        chk($sformatf("tbl%0d_iss_opa", i), iss_opa, v.e_opa);
        chk($sformatf("tbl%0d_iss_opb", i), iss_opb, v.e_opb);
      end
      if (v.e_iv) chk($sformatf("tbl%0d_iss_dest", i), 32'(iss_rob_dest), 32'(v.e_dest));
    end
    rst = 1'b0; cdb_valid = 1'b0;

    // ALU back-pressure: issue register holds while ex_ready is low
    ex_ready = 1'b0;
    drv_dp(1'b1, 32'hA1, 32'hB1, 3'd1); tick();
    chk("stall_alloc_cnt", 32'(rs_count), 32'd1);
    drv_dp(1'b1, 32'hA2, 32'hB2, 3'd2); tick();
    chk("stall_first_iv", 32'(iss_valid), 32'd1);
    chk("stall_first_cnt", 32'(rs_count), 32'd1);
    drv_dp(1'b0, 0, 0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_iv", k), 32'(iss_valid), 32'd1);
      chk($sformatf("stall%0d_dest", k), 32'(iss_rob_dest), 32'd1);
      chk($sformatf("stall%0d_opa", k), iss_opa, 32'hA1);
      chk($sformatf("stall%0d_pc", k), iss_pc, 32'h2001);
    end
    ex_ready = 1'b1; tick();
    chk("stall_next_dest", 32'(iss_rob_dest), 32'd2);
    chk("stall_next_opa", iss_opa, 32'hA2);
    chk("stall_next_cnt", 32'(rs_count), 32'd0);
    tick();
    chk("stall_drain_iv", 32'(iss_valid), 32'd0);

    // flush with three held entries and a stalled issue register
    ex_ready = 1'b0;
    for (int k = 3; k < 7; k++) begin
      drv_dp(1'b1, 32'(k), 32'(k + 16), 3'(k));
      tick();
    end
    chk("preflush_cnt", 32'(rs_count), 32'd3);
    chk("preflush_iv", 32'(iss_valid), 32'd1);
    flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 32'hDEAD;
    drv_dp(1'b1, 32'h77, 32'h88, 3'd7); tick();
    chk("flush_cnt", 32'(rs_count), 32'd0);
    chk("flush_iv", 32'(iss_valid), 32'd0);
    chk("flush_full", 32'(rs_full), 32'd0);
    chk("flush_keeps_dest", 32'(iss_rob_dest), 32'd3);
    flush = 1'b0; cdb_valid = 1'b0; ex_ready = 1'b1;
    drv_dp(1'b0, 0, 0, 3'd0); tick();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 499) == 0);
      flush       = ($urandom_range(0, 79) == 0);
      dp_valid    = ($urandom_range(0, 9) < 6);
      dp_pc       = $urandom;
      dp_alu_ctrl = 4'($urandom_range(0, 15));
      dp_rob_dest = 3'($urandom_range(0, 7));
      dp_opa_rdy  = 1'($urandom_range(0, 1));
      dp_opa_val  = $urandom;
      dp_opa_tag  = 3'($urandom_range(0, 7));
      dp_opb_rdy  = 1'($urandom_range(0, 1));
      dp_opb_val  = $urandom;
      dp_opb_tag  = 3'($urandom_range(0, 7));
      cdb_valid   = ($urandom_range(0, 9) < 4);
      cdb_tag     = 3'($urandom_range(0, 7));
      cdb_value   = $urandom;
      ex_ready    = 1'($urandom_range(0, 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
